// File: rtl/pixel_pipe_pkg.sv
// Shared types and constants for the layered pixel pipeline.
package pixel_pipe_pkg;

  // Layer that owns a pixel, before the sprite texel is known.
  typedef enum logic [2:0] {L_DBG, L_CHAR, L_OBST, L_MAP, L_WALL, L_BG} layer_e;

  typedef enum logic {CAM_IDLE, CAM_SCROLL} cam_state_e;

  // Per-pixel tag carried alongside the ROM reads.
  typedef struct packed {
    logic   chr;
    layer_e lay;
  } pix_tag_t;

  localparam logic [11:0] MAP_COLOR  = 12'h2A4;
  localparam logic [11:0] WALL_COLOR = 12'h777;
  localparam logic [11:0] BLACK      = 12'h000;
  localparam int          PIPE_LAT   = 3;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obstacle_priority_hit.sv
// Parallel obstacle hit tests with lowest-index-wins priority encoding.
module obstacle_priority_hit
  import pixel_pipe_pkg::*;
#(
  parameter int PHY_WIDTH       = 14,
  parameter int OBSTACLE_NUM    = 7,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int OBSTACLE_HEIGHT = 20,
  parameter int BLOCK_LEN_WIDTH = 4,
  localparam int ID_W = idx_w(OBSTACLE_NUM),
  localparam int TX_W = idx_w(OBSTACLE_WIDTH),
  localparam int TY_W = idx_w(OBSTACLE_HEIGHT)
) (
  input  logic [PHY_WIDTH-1:0]                    wx_i,
  input  logic [PHY_WIDTH-1:0]                    wy_i,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       pos_x_i,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       pos_y_i,
  input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] blk_w_i,
  input  logic [OBSTACLE_NUM-1:0]                 en_i,
  output logic                                    hit_any_o,
  output logic [ID_W-1:0]                         hit_id_o,
  output logic [OBSTACLE_NUM-1:0][TX_W-1:0]       tx_o,
  output logic [OBSTACLE_NUM-1:0][TY_W-1:0]       ty_o
);

  localparam int PW1 = PHY_WIDTH + 1;

  logic [OBSTACLE_NUM-1:0] hit;

  for (genvar i = 0; i < OBSTACLE_NUM; i++) begin : g_slot
    logic [PHY_WIDTH-1:0]       ox, oy;
    logic [BLOCK_LEN_WIDTH-1:0] bw;
    logic [PHY_WIDTH:0]         hx, hy;
    assign ox = pos_x_i[i*PHY_WIDTH +: PHY_WIDTH];
    assign oy = pos_y_i[i*PHY_WIDTH +: PHY_WIDTH];
    assign bw = blk_w_i[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
    // Upper bounds one bit wider so a slot near the top of world space cannot wrap.
    assign hx = {1'b0, ox} + PW1'(bw) * PW1'(OBSTACLE_WIDTH);
    assign hy = {1'b0, oy} + PW1'(OBSTACLE_HEIGHT);
    assign hit[i] = en_i[i] && (bw != '0) &&
                    (wx_i >= ox) && ({1'b0, wx_i} < hx) &&
                    (wy_i >= oy) && ({1'b0, wy_i} < hy);
    assign tx_o[i] = TX_W'((wx_i - ox) % PHY_WIDTH'(OBSTACLE_WIDTH));
    assign ty_o[i] = TY_W'(wy_i - oy);
  end

  // Scan from the top down so the lowest hitting slot is the last to write.
  always_comb begin
    hit_any_o = |hit;
    hit_id_o  = '0;
    for (int i = OBSTACLE_NUM - 1; i >= 0; i--)
      if (hit[i]) hit_id_o = ID_W'(i);
  end

endmodule

// File: rtl/layered_pixel_pipeline.sv
// Three-stage layered pixel compositor with frame-synchronous camera scrolling.
module layered_pixel_pipeline
  import pixel_pipe_pkg::*;
#(
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 14,
  parameter int PIXEL_WIDTH     = 12,
  parameter int OBSTACLE_NUM    = 7,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int OBSTACLE_HEIGHT = 20,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int CHAR_WIDTH_X    = 42,
  parameter int CHAR_WIDTH_Y    = 52,
  parameter int BLOCK_WIDTH     = 480,
  parameter int CAM_WIDTH       = 5,
  parameter int SCROLL_STEP     = 8,
  parameter int MAP_X_OFFSET    = 120,
  parameter int MAP_WIDTH_X     = 480,
  parameter int WALL_WIDTH      = 10,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT = 12'hF0F,
  localparam int CHAR_AW = $clog2(CHAR_WIDTH_X*CHAR_WIDTH_Y),
  localparam int TILE_AW = $clog2(OBSTACLE_WIDTH*OBSTACLE_HEIGHT)
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst_n,
  input  logic                                    video_on,
  input  logic                                    frame_start,
  input  logic [SCREEN_WIDTH-1:0]                 x,
  input  logic [SCREEN_WIDTH-1:0]                 y,
  input  logic [CAM_WIDTH-1:0]                    camera_y,
  input  logic [PHY_WIDTH-1:0]                    char_abs_x,
  input  logic [PHY_WIDTH-1:0]                    char_abs_y,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_x,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_y,
  input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width,
  input  logic [OBSTACLE_NUM-1:0]                 obstacle_enable,
  input  logic                                    debug_on,
  input  logic [PIXEL_WIDTH-1:0]                  debug_rgb,
  output logic [CHAR_AW-1:0]                      char_rom_addr,
  input  logic [PIXEL_WIDTH-1:0]                  char_rom_data,
  output logic [TILE_AW-1:0]                      tile_rom_addr,
  input  logic [PIXEL_WIDTH-1:0]                  tile_rom_data,
  output logic [PIXEL_WIDTH-1:0]                  rgb,
  output logic                                    rgb_valid,
  output logic                                    scroll_busy
);

  localparam int ID_W = idx_w(OBSTACLE_NUM);
  localparam int TX_W = idx_w(OBSTACLE_WIDTH);
  localparam int TY_W = idx_w(OBSTACLE_HEIGHT);
  localparam int SW1  = SCREEN_WIDTH + 1;
  localparam logic [SCREEN_WIDTH:0] MAP_L  = SW1'(MAP_X_OFFSET);
  localparam logic [SCREEN_WIDTH:0] MAP_R  = SW1'(MAP_X_OFFSET + MAP_WIDTH_X);
  localparam logic [SCREEN_WIDTH:0] IN_L   = SW1'(MAP_X_OFFSET + WALL_WIDTH);
  localparam logic [SCREEN_WIDTH:0] IN_R   = SW1'(MAP_X_OFFSET + MAP_WIDTH_X - WALL_WIDTH);
  localparam logic [SCREEN_WIDTH:0] WALL_Y = SW1'(WALL_WIDTH);
  localparam logic [PHY_WIDTH:0]    CHR_W  = (PHY_WIDTH+1)'(CHAR_WIDTH_X);
  localparam logic [PHY_WIDTH:0]    CHR_H  = (PHY_WIDTH+1)'(CHAR_WIDTH_Y);
  localparam logic [PHY_WIDTH-1:0]  STEP_P = PHY_WIDTH'(SCROLL_STEP);

  // ---------------- camera ----------------
  cam_state_e           state_q, state_d;
  logic [PHY_WIDTH-1:0] cam_cur_q, cam_cur_d, cam_tgt_q, cam_tgt_d;
  logic [PHY_WIDTH-1:0] tgt_req, gap, step;
  logic                 up;

  assign tgt_req     = PHY_WIDTH'(camera_y) * PHY_WIDTH'(BLOCK_WIDTH);
  assign up          = (tgt_req >= cam_cur_q);
  assign gap         = up ? (tgt_req - cam_cur_q) : (cam_cur_q - tgt_req);
  assign step        = (gap > STEP_P) ? STEP_P : gap;
  assign scroll_busy = (cam_cur_q != cam_tgt_q);

  // Camera state register; only frame_start moves it so a frame sees one offset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= CAM_IDLE;
      cam_cur_q <= '0;
      cam_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      cam_cur_q <= cam_cur_d;
      cam_tgt_q <= cam_tgt_d;
    end
  end

  // Next camera state: the freshly requested target is always honoured, and
  // the step direction is recomputed from it, so mid-scroll reversals just work.
  always_comb begin
    state_d   = state_q;
    cam_cur_d = cam_cur_q;
    cam_tgt_d = cam_tgt_q;
    if (frame_start) begin
      cam_tgt_d = tgt_req;
      if (SCROLL_STEP == 0) begin
        cam_cur_d = tgt_req;
        state_d   = CAM_IDLE;
      end else if (state_q == CAM_SCROLL || tgt_req != cam_cur_q) begin
        cam_cur_d = up ? (cam_cur_q + step) : (cam_cur_q - step);
        state_d   = (cam_cur_d == tgt_req) ? CAM_IDLE : CAM_SCROLL;
      end
    end
  end

  // ---------------- stage 1: hit tests and ROM addresses ----------------
  logic [PHY_WIDTH-1:0]               wx, wy;
  logic                               chr_hit, map_in, wall, hit_any;
  logic [ID_W-1:0]                    hit_id;
  logic [OBSTACLE_NUM-1:0][TX_W-1:0]  tx_all;
  logic [OBSTACLE_NUM-1:0][TY_W-1:0]  ty_all;
  logic [TX_W-1:0]                    tx_sel;
  logic [TY_W-1:0]                    ty_sel;
  layer_e                             lay1;

  assign wx = PHY_WIDTH'(x);
  assign wy = PHY_WIDTH'(y) + cam_cur_q;

  assign chr_hit = (wx >= char_abs_x) && ({1'b0, wx} < {1'b0, char_abs_x} + CHR_W) &&
                   (wy >= char_abs_y) && ({1'b0, wy} < {1'b0, char_abs_y} + CHR_H);

  assign map_in = ({1'b0, x} >= IN_L) && ({1'b0, x} < IN_R) && ({1'b0, y} >= WALL_Y);
  assign wall   = ({1'b0, x} >= MAP_L) && ({1'b0, x} < MAP_R) && !map_in;

  obstacle_priority_hit #(
    .PHY_WIDTH      (PHY_WIDTH),
    .OBSTACLE_NUM   (OBSTACLE_NUM),
    .OBSTACLE_WIDTH (OBSTACLE_WIDTH),
    .OBSTACLE_HEIGHT(OBSTACLE_HEIGHT),
    .BLOCK_LEN_WIDTH(BLOCK_LEN_WIDTH)
  ) u_obst (
    .wx_i     (wx),
    .wy_i     (wy),
    .pos_x_i  (obstacle_abs_pos_x),
    .pos_y_i  (obstacle_abs_pos_y),
    .blk_w_i  (obstacle_block_width),
    .en_i     (obstacle_enable),
    .hit_any_o(hit_any),
    .hit_id_o (hit_id),
    .tx_o     (tx_all),
    .ty_o     (ty_all)
  );

  // The single tile port serves the winning obstacle, else the screen-tiled background.
  assign tx_sel = hit_any ? tx_all[hit_id] : TX_W'(x % SCREEN_WIDTH'(OBSTACLE_WIDTH));
  assign ty_sel = hit_any ? ty_all[hit_id] : TY_W'(y % SCREEN_WIDTH'(OBSTACLE_HEIGHT));

  // Fallback layer if the sprite turns out transparent or absent.
  always_comb begin
    lay1 = L_BG;
    if      (debug_on) lay1 = L_DBG;
    else if (hit_any)  lay1 = L_OBST;
    else if (map_in)   lay1 = L_MAP;
    else if (wall)     lay1 = L_WALL;
  end

  logic [CHAR_AW-1:0]      chr_addr_q;
  logic [TILE_AW-1:0]      tile_addr_q;
  pix_tag_t                tag1_q, tag2_q;
  logic [PIXEL_WIDTH-1:0]  dbg1_q, dbg2_q, rgb_q, rgb_d;
  logic [PIPE_LAT-1:0]     vld_pipe_q;

  assign char_rom_addr = chr_addr_q;
  assign tile_rom_addr = tile_addr_q;
  assign rgb           = rgb_q;
  assign rgb_valid     = vld_pipe_q[PIPE_LAT-1];

  // ---------------- stage 3: output mux ----------------
  always_comb begin
    rgb_d = PIXEL_WIDTH'(BLACK);
    if (vld_pipe_q[1]) begin
      if (tag2_q.lay == L_DBG)                         rgb_d = dbg2_q;
      else if (tag2_q.chr && char_rom_data != TRANSPARENT) rgb_d = char_rom_data;
      else begin
        case (tag2_q.lay)
          L_MAP:   rgb_d = PIXEL_WIDTH'(MAP_COLOR);
          L_WALL:  rgb_d = PIXEL_WIDTH'(WALL_COLOR);
          default: rgb_d = tile_rom_data;
        endcase
      end
    end
  end

  // Pipeline registers: S1 addresses/tags, S2 waits on ROM data, S3 registers rgb.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      chr_addr_q  <= '0;
      tile_addr_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      dbg1_q      <= '0;
      dbg2_q      <= '0;
      rgb_q       <= '0;
      vld_pipe_q  <= '0;
    end else begin
      chr_addr_q  <= chr_hit ? CHAR_AW'((wy - char_abs_y) * PHY_WIDTH'(CHAR_WIDTH_X) + (wx - char_abs_x))
                             : '0;
      tile_addr_q <= TILE_AW'(ty_sel) * TILE_AW'(OBSTACLE_WIDTH) + TILE_AW'(tx_sel);
      tag1_q      <= '{chr: chr_hit, lay: lay1};
      tag2_q      <= tag1_q;
      dbg1_q      <= debug_rgb;
      dbg2_q      <= dbg1_q;
      rgb_q       <= rgb_d;
      vld_pipe_q  <= {vld_pipe_q[PIPE_LAT-2:0], video_on};
    end
  end

endmodule

// File: tb/tb_layered_pixel_pipeline.sv
// Directed bench: latency, obstacle priority, transparency, map/wall, camera scrolling.
module tb_layered_pixel_pipeline;

  localparam logic [11:0] MAPC  = 12'h2A4;
  localparam logic [11:0] WALLC = 12'h777;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        video_on, frame_start, debug_on;
  logic [9:0]  x, y;
  logic [4:0]  camera_y;
  logic [13:0] char_x, char_y;
  logic [97:0] obs_x, obs_y;
  logic [27:0] obs_w;
  logic [6:0]  obs_en;
  logic [11:0] debug_rgb, char_tex;
  logic [11:0] char_rom_data = '0, tile_rom_data = '0;
  logic [11:0] char_rom_addr, c0_caddr;
  logic [7:0]  tile_rom_addr, c0_taddr;
  logic [11:0] rgb, c0_rgb;
  logic        rgb_valid, scroll_busy, c0_vld, c0_busy;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROM models: one-cycle read latency.
  always @(posedge clk) begin
    tile_rom_data <= 12'hA00 | {4'h0, tile_rom_addr};
    char_rom_data <= char_tex;
  end

  layered_pixel_pipeline dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .video_on(video_on), .frame_start(frame_start),
    .x(x), .y(y), .camera_y(camera_y), .char_abs_x(char_x), .char_abs_y(char_y),
    .obstacle_abs_pos_x(obs_x), .obstacle_abs_pos_y(obs_y),
    .obstacle_block_width(obs_w), .obstacle_enable(obs_en),
    .debug_on(debug_on), .debug_rgb(debug_rgb),
    .char_rom_addr(char_rom_addr), .char_rom_data(char_rom_data),
    .tile_rom_addr(tile_rom_addr), .tile_rom_data(tile_rom_data),
    .rgb(rgb), .rgb_valid(rgb_valid), .scroll_busy(scroll_busy));

  layered_pixel_pipeline #(.SCROLL_STEP(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .video_on(video_on), .frame_start(frame_start),
    .x(x), .y(y), .camera_y(camera_y), .char_abs_x(char_x), .char_abs_y(char_y),
    .obstacle_abs_pos_x(obs_x), .obstacle_abs_pos_y(obs_y),
    .obstacle_block_width(obs_w), .obstacle_enable(obs_en),
    .debug_on(debug_on), .debug_rgb(debug_rgb),
    .char_rom_addr(c0_caddr), .char_rom_data(char_rom_data),
    .tile_rom_addr(c0_taddr), .tile_rom_data(tile_rom_data),
    .rgb(c0_rgb), .rgb_valid(c0_vld), .scroll_busy(c0_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [13:0] px, input logic [13:0] py,
                          input logic [3:0] w, input logic en);
    obs_x[i*14 +: 14] = px;
    obs_y[i*14 +: 14] = py;
    obs_w[i*4 +: 4]   = w;
    obs_en[i]         = en;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 7; i++) set_slot(i, 14'h3000, 14'h3000, 4'd0, 1'b0);
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    x = px; y = py;
  endtask

  task automatic frame(input logic [4:0] c);
    camera_y = c; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    video_on = 1'b1; frame_start = 1'b0; debug_on = 1'b0; debug_rgb = 12'h000;
    camera_y = '0; char_x = 14'h3000; char_y = 14'h3000; char_tex = 12'h000;
    obs_x = '0; obs_y = '0; obs_w = '0; obs_en = '0;
    clear_slots();
    pix(10'd125, 10'd5);

    // reset holds everything at zero even with video_on high
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_vld", rgb_valid, 0);
    chk("rst_caddr", char_rom_addr, 0);
    chk("rst_taddr", tile_rom_addr, 0);
    chk("rst_busy", scroll_busy, 0);

    // back-to-back pixels: each appears exactly 3 cycles later
    rst_n = 1'b1;                                   // A = (125,5) wall
    @(negedge clk); chk("lat_c1", {rgb_valid, rgb}, 0);
    pix(10'd300, 10'd200);                          // B map interior
    @(negedge clk); chk("lat_c2", {rgb_valid, rgb}, 0);
    pix(10'd53, 10'd307);                           // C background, tile 73
    @(negedge clk); chk("wall", rgb, WALLC); chk("vld_A", rgb_valid, 1);
    pix(10'd200, 10'd100); debug_on = 1'b1; debug_rgb = 12'h5C3;   // D debug
    @(negedge clk); chk("map", rgb, MAPC);
    chk("chr_miss_addr", char_rom_addr, 0);
    video_on = 1'b0; debug_on = 1'b0; pix(10'd300, 10'd200);       // E blank
    @(negedge clk); chk("bg", rgb, 12'hA49);
    video_on = 1'b1;
    @(negedge clk); chk("debug", rgb, 12'h5C3);
    @(negedge clk); chk("blank", {rgb_valid, rgb}, 0);

    // overlapping slots 2 and 5: lowest index wins
    set_slot(2, 14'd195, 14'd95, 4'd1, 1'b1);
    set_slot(5, 14'd180, 14'd90, 4'd3, 1'b1);
    pix(10'd200, 10'd100);
    @(negedge clk); chk("prio_addr2", tile_rom_addr, 55);
    repeat (2) @(negedge clk); chk("prio_rgb2", rgb, 12'hA37);
    obs_en[2] = 1'b0;
    @(negedge clk); chk("prio_addr5", tile_rom_addr, 100);
    repeat (2) @(negedge clk); chk("prio_rgb5", rgb, 12'hA64);
    obs_en = '1; obs_w = '0;
    @(negedge clk); chk("bw0_addr", tile_rom_addr, 0);
    repeat (2) @(negedge clk); chk("bw0_rgb", rgb, MAPC);

    // transparent sprite over obstacle slot 0
    clear_slots();
    set_slot(0, 14'd140, 14'd45, 4'd2, 1'b1);
    char_x = 14'd150; char_y = 14'd50; char_tex = 12'hF0F;
    pix(10'd155, 10'd60);
    @(negedge clk); chk("chr_addr", char_rom_addr, 425); chk("obs_addr", tile_rom_addr, 155);
    repeat (2) @(negedge clk); chk("transp_obst", rgb, 12'hA9B);
    char_tex = 12'h00F;
    repeat (3) @(negedge clk); chk("chr_texel", rgb, 12'h00F);
    obs_en[0] = 1'b0; char_tex = 12'hF0F;
    repeat (3) @(negedge clk); chk("transp_map", rgb, MAPC);

    // scroll up halfway, then reverse mid-scroll
    for (int k = 1; k <= 30; k++) begin
      frame(5'd1);
      if (k == 1) begin
        chk("jump_cur", dut0.cam_cur_q, 480);
        chk("jump_busy", c0_busy, 0);
      end
    end
    chk("half_cur", dut.cam_cur_q, 240);
    chk("half_busy", scroll_busy, 1);
    frame(5'd0);
    chk("rev_cur", dut.cam_cur_q, 232);
    chk("rev_busy", scroll_busy, 1);
    chk("jump_back", dut0.cam_cur_q, 0);
    chk("jump_busy2", c0_busy, 0);
    repeat (29) frame(5'd0);
    chk("home_cur", dut.cam_cur_q, 0);
    chk("home_busy", scroll_busy, 0);

    // full scroll 0 -> 480 in 8-pixel steps
    for (int k = 1; k <= 60; k++) begin
      frame(5'd1);
      chk($sformatf("scr_cur%0d", k), dut.cam_cur_q, 8 * k);
      chk($sformatf("scr_busy%0d", k), scroll_busy, (k < 60) ? 1 : 0);
    end
    frame(5'd1);
    chk("hold_cur", dut.cam_cur_q, 480);

    // world y now includes the camera offset
    char_y = 14'd530;
    @(negedge clk); chk("cam_chr_addr", char_rom_addr, 425);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
